// File: rtl/nios_mult_pipe.sv
// rtl/nios_mult_pipe.sv - two-stage WIDTH x WIDTH multiplier with valid/ready handshake
// Half-width partial products in S1; summation, sign correction and half select in S2.
module nios_mult_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int H = WIDTH / 2;
  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_XSU = 2'd2;
  localparam logic [1:0] OP_XSS = 2'd3;

  logic             adv;
  logic             s1_valid_q, out_valid_q;
  logic [WIDTH-1:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
  logic [WIDTH-1:0] pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [1:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q, out_tag_q;
  logic             a_neg_q, b_neg_q, a_neg_d, b_neg_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [WIDTH:0]   mid;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] corr;

  // One global advance: an empty or draining output stage lets everything move.
  assign adv        = ~out_valid_q | out_ready;
  assign in_ready   = adv;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

  always_comb begin
    pp_ll_d = {{H{1'b0}}, in_a[H-1:0]}     * {{H{1'b0}}, in_b[H-1:0]};
    pp_lh_d = {{H{1'b0}}, in_a[H-1:0]}     * {{H{1'b0}}, in_b[WIDTH-1:H]};
    pp_hl_d = {{H{1'b0}}, in_a[WIDTH-1:H]} * {{H{1'b0}}, in_b[H-1:0]};
    pp_hh_d = {{H{1'b0}}, in_a[WIDTH-1:H]} * {{H{1'b0}}, in_b[WIDTH-1:H]};
    a_neg_d = in_a[WIDTH-1] & ((in_op == OP_XSU) | (in_op == OP_XSS));
    b_neg_d = in_b[WIDTH-1] & (in_op == OP_XSS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      pp_ll_q    <= '0;
      pp_lh_q    <= '0;
      pp_hl_q    <= '0;
      pp_hh_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        pp_ll_q  <= pp_ll_d;
        pp_lh_q  <= pp_lh_d;
        pp_hl_q  <= pp_hl_d;
        pp_hh_q  <= pp_hh_d;
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_op_q  <= in_op;
        s1_tag_q <= in_tag;
        a_neg_q  <= a_neg_d;
        b_neg_q  <= b_neg_d;
      end
    end
  end

  // Unsigned product, then the two's-complement correction only touches the high half.
  always_comb begin
    mid  = {1'b0, pp_lh_q} + {1'b0, pp_hl_q};
    prod = {pp_hh_q, pp_ll_q} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
    corr = (a_neg_q ? s1_b_q : '0) + (b_neg_q ? s1_a_q : '0);
    if (s1_op_q == OP_MUL) out_result_d = prod[WIDTH-1:0];
    else                   out_result_d = prod[2*WIDTH-1:WIDTH] - corr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (adv) begin
      out_valid_q  <= s1_valid_q;
      out_result_q <= out_result_d;
      out_tag_q    <= s1_tag_q;
    end
  end

endmodule

// File: tb/tb_nios_mult_pipe.sv
// tb/tb_nios_mult_pipe.sv - self-checking bench for nios_mult_pipe
// Directed spec vectors plus randomized traffic against a wide-integer reference model.
module tb_nios_mult_pipe;

  logic        clk, reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_res_q[$];
  logic [4:0]  exp_tag_q[$];
  logic        cur_uc;
  logic [31:0] cur_ce;
  logic        hold_v = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_tag;

  nios_mult_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [127:0] ea, eb, p;
    ea = (op >= 2'd2) ? {{96{a[31]}}, a} : {96'b0, a};
    eb = (op == 2'd3) ? {{96{b[31]}}, b} : {96'b0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic uc, input logic [31:0] ce);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag;
    cur_uc = uc; cur_ce = ce;
    #1;
  endtask

  task automatic cycle();
    if (hold_v) begin
      chk("stall_valid", {63'b0, out_valid}, 64'd1);
      chk("stall_result", {32'b0, out_result}, {32'b0, held_res});
      chk("stall_tag", {59'b0, out_tag}, {59'b0, held_tag});
    end
    if (out_valid && out_ready) begin
      if (exp_res_q.size() == 0) chk("spurious_out", {63'b0, out_valid}, 64'd0);
      else begin
        chk("result", {32'b0, out_result}, {32'b0, exp_res_q.pop_front()});
        chk("tag", {59'b0, out_tag}, {59'b0, exp_tag_q.pop_front()});
      end
    end
    if (in_valid && in_ready) begin
      exp_res_q.push_back(cur_uc ? cur_ce : model(in_op, in_a, in_b));
      exp_tag_q.push_back(in_tag);
    end
    hold_v   = out_valid & ~out_ready;
    held_res = out_result;
    held_tag = out_tag;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
      cycle();
    end
  endtask

  initial begin
    logic [31:0] ta[4];
    logic [31:0] tb[4];
    int          idx;
    logic        acc;

    reset = 1'b1; out_ready = 1'b1;
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    @(negedge clk); @(negedge clk);
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result", {32'b0, out_result}, 64'd0);
    chk("rst_tag", {59'b0, out_tag}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    reset = 1'b0;
    idle(2);

    // Spec vector 1 with latency check
    drive(1'b1, 2'd0, 32'h0001_0002, 32'h0003_0004, 5'd1, 1'b1, 32'h000A_0008);
    cycle();
    drive(1'b1, 2'd1, 32'h0001_0002, 32'h0003_0004, 5'd2, 1'b1, 32'h0000_0003);
    chk("lat_not_yet", {63'b0, out_valid}, 64'd0);
    cycle();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    chk("lat_valid", {63'b0, out_valid}, 64'd1);
    chk("v1_mul", {32'b0, out_result}, 64'h000A_0008);
    cycle();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    chk("v1_mulxuu", {32'b0, out_result}, 64'h0000_0003);
    cycle();
    idle(2);

    // Spec vectors 2 and 3, back to back
    drive(1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'h0000_0001); cycle();
    drive(1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1, 32'hFFFF_FFFE); cycle();
    drive(1'b1, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1, 32'hFFFF_FFFF); cycle();
    drive(1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1, 32'h0000_0000); cycle();
    drive(1'b1, 2'd3, 32'h8000_0000, 32'h8000_0000, 5'd7, 1'b1, 32'h4000_0000); cycle();
    drive(1'b1, 2'd1, 32'h8000_0000, 32'h8000_0000, 5'd8, 1'b1, 32'h4000_0000); cycle();
    drive(1'b1, 2'd2, 32'h8000_0000, 32'h8000_0000, 5'd9, 1'b1, 32'hC000_0000); cycle();
    idle(3);
    chk("dir_drain", exp_res_q.size(), 64'd0);

    // Eight back-to-back ops: valid in cycles 2..9
    for (int k = 0; k < 11; k++) begin
      drive(k < 8, 2'(k % 4), 32'(k * 1000 + 17), 32'hF000_0003 - 32'(k), 5'(k), 1'b0, 32'd0);
      chk($sformatf("b2b_valid_%0d", k), {63'b0, out_valid}, {63'b0, (k >= 2 && k < 10)});
      cycle();
    end
    chk("b2b_drain", exp_res_q.size(), 64'd0);

    // Backpressure: only two ops fit before the input stalls
    for (int i = 0; i < 4; i++) begin ta[i] = $urandom; tb[i] = $urandom; end
    out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 40 && (idx < 4 || exp_res_q.size() > 0); k++) begin
      if (k == 6) out_ready = 1'b1;
      drive(idx < 4, 2'(idx % 4), ta[idx % 4], tb[idx % 4], 5'(16 + idx), 1'b0, 32'd0);
      if (k == 2) chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
      acc = in_valid & in_ready;
      cycle();
      if (acc) idx++;
    end
    chk("bp_issued", idx, 64'd4);
    chk("bp_drain", exp_res_q.size(), 64'd0);

    // Randomized traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ra, rb;
      out_ready = ($urandom_range(0, 3) != 0);
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'd0;
        3: rb = 32'h7FFF_FFFF;
        default: ;
      endcase
      drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), ra, rb, 5'($urandom), 1'b0, 32'd0);
      cycle();
    end
    out_ready = 1'b1;
    idle(4);
    chk("rand_drain", exp_res_q.size(), 64'd0);

    // Asynchronous reset with two ops in flight
    drive(1'b1, 2'd0, 32'd11, 32'd13, 5'd20, 1'b1, 32'd143); cycle();
    drive(1'b1, 2'd1, 32'hFFFF_0000, 32'hFFFF_0000, 5'd21, 1'b0, 32'd0); cycle();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    reset = 1'b1;
    #1;
    chk("arst_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_result", {32'b0, out_result}, 64'd0);
    chk("arst_in_ready", {63'b0, in_ready}, 64'd1);
    exp_res_q.delete(); exp_tag_q.delete();
    hold_v = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 2'd0, 32'd7, 32'd6, 5'd9, 1'b1, 32'd42); cycle();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    chk("post_rst_empty", {63'b0, out_valid}, 64'd0);
    cycle();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    chk("post_rst_result", {32'b0, out_result}, 64'd42);
    cycle();
    idle(3);
    chk("post_rst_drain", exp_res_q.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
